// File: rtl/apb4_master_pkg.sv
// Shared types and constants for the APB4 master bridge.
// The optional ACCESS timeout is enabled by defining APB4_MASTER_TIMEOUT_EN.
package apb4_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB4_PROT_WIDTH              = 3;
    localparam int APB4_TIMEOUT_CYCLES_DEFAULT  = 256;

endpackage

// File: rtl/apb4_master_bridge_tmo.sv
// Saturating ACCESS-cycle counter for the APB4 master bridge.
// Only instantiated when APB4_MASTER_TIMEOUT_EN is defined.
module apb4_master_tmo #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over count; the count stops at the last ACCESS cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the final permitted ACCESS cycle.
    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/apb4_master_bridge.sv
// Single-outstanding APB4 initiator: valid/ready command in, APB4
// SETUP/ACCESS on the bus, valid/ready response out.
// Define APB4_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module apb4_master_bridge
    import apb4_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = APB4_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_write_i,
    input  logic [ADDR_WIDTH-1:0]      req_addr_i,
    input  logic [DATA_WIDTH-1:0]      req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]    req_strb_i,
    input  logic [APB4_PROT_WIDTH-1:0] req_prot_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic [ADDR_WIDTH-1:0]      paddr_o,
    output logic [APB4_PROT_WIDTH-1:0] pprot_o,
    output logic                       psel_o,
    output logic                       penable_o,
    output logic                       pwrite_o,
    output logic [DATA_WIDTH-1:0]      pwdata_o,
    output logic [DATA_WIDTH/8-1:0]    pstrb_o,
    input  logic                       pready_i,
    input  logic [DATA_WIDTH-1:0]      prdata_i,
    input  logic                       pslverr_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    apb_state_e                 state_q, state_d;
    logic                       idle_q, idle_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic                       pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]      paddr_q, paddr_d;
    logic [APB4_PROT_WIDTH-1:0] pprot_q, pprot_d;
    logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]      pstrb_q, pstrb_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;

    logic accept_s;
    logic done_s;
    logic tmo_expired_s;

`ifdef APB4_MASTER_TIMEOUT_EN
    apb4_master_tmo #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_d == SETUP),
        .en_i      (state_q == ACCESS),
        .expired_o (tmo_expired_s)
    );
`else
    // Without the counter ACCESS waits forever; this folds to constant 0.
    assign tmo_expired_s = (TIMEOUT_CYCLES < 32'sd0);
`endif

    // A command is taken in IDLE, or in RESP in the same cycle the response is consumed.
    assign accept_s = req_valid_i && req_ready_o;
    // pready wins over a timeout expiring in the same ACCESS cycle.
    assign done_s   = (state_q == ACCESS) && (pready_i || tmo_expired_s);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) state_d = SETUP;
                else             state_d = IDLE;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (done_s) state_d = RESP;
                else        state_d = ACCESS;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    if (req_valid_i) state_d = SETUP;
                    else             state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values, derived from the next state so every output is a flop.
    always_comb begin
        idle_d      = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);

        if (accept_s) begin
            pwrite_d = req_write_i;
            paddr_d  = req_addr_i;
            pprot_d  = req_prot_i;
            pwdata_d = req_wdata_i;
            pstrb_d  = req_write_i ? req_strb_i : {STRB_WIDTH{1'b0}};
        end else begin
            pwrite_d = pwrite_q;
            paddr_d  = paddr_q;
            pprot_d  = pprot_q;
            pwdata_d = pwdata_q;
            pstrb_d  = pstrb_q;
        end

        if (done_s) begin
            if (pready_i) begin
                rsp_err_d   = pslverr_i;
                rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : {DATA_WIDTH{1'b0}};
            end else begin
                rsp_err_d   = 1'b1;
                rsp_rdata_d = {DATA_WIDTH{1'b0}};
            end
        end else begin
            rsp_err_d   = rsp_err_q;
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    // Output and command/response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_q      <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= {ADDR_WIDTH{1'b0}};
            pprot_q     <= {APB4_PROT_WIDTH{1'b0}};
            pwdata_q    <= {DATA_WIDTH{1'b0}};
            pstrb_q     <= {STRB_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            idle_q      <= idle_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pprot_q     <= pprot_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // In RESP the bridge can take a new command only as the response drains,
    // so ready there follows rsp_ready_i; elsewhere it is the registered idle flag.
    assign req_ready_o = idle_q || (rsp_valid_q && rsp_ready_i);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign paddr_o     = paddr_q;
    assign pprot_o     = pprot_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;

endmodule
